// File: rtl/ah_rr_burst_scheduler.sv
// rtl/ah_rr_burst_scheduler.sv - burst-level round-robin scheduler for the shared AH datapath
//
// Grants one requester for a whole burst of up to 16 beats, counts accepted
// beats, releases on burst completion or early release, inserts a one-cycle
// turnaround and rotates priority to the requester after the previous owner.
//
// Optional feature macro: AH_RRS_TIMEOUT_EN (stall-timeout abort of a burst).
//
// Parameters:
//   N        number of requesters (2..16)
//   PW       owner index width, 2^PW >= N
//   TIMEOUT  stall-cycle limit when AH_RRS_TIMEOUT_EN is defined (1..255)
//
// Ports:
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   req         per-requester burst request (level, held for the burst)
//   beat_valid  per-requester beat valid
//   burst_len   beats per burst, 0 encodes 16, sampled at grant
//   res_ready   shared resource accepts the current beat
//   grant       registered one-hot owner, zero when idle or in the gap
//   grant_id    index of the current owner, zero when no grant
//   res_valid   owner's beat_valid while bursting
//   res_last    current beat is the final counted beat of the burst
//   busy        scheduler not idle
//   timeout     one-cycle abort pulse (tied low without AH_RRS_TIMEOUT_EN)

module ah_rr_burst_scheduler #(
    parameter int N       = 12,
    parameter int PW      = 4,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  beat_valid,
    input  logic [3:0]    burst_len,
    input  logic          res_ready,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_id,
    output logic          res_valid,
    output logic          res_last,
    output logic          busy,
    output logic          timeout
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BURST = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    // Elaboration-time parameter sanity checks.
    if (N < 2 || N > 16) begin : g_bad_n
        $error("ah_rr_burst_scheduler: N must be 2..16");
    end
    if ((1 << PW) < N) begin : g_bad_pw
        $error("ah_rr_burst_scheduler: PW too narrow for N");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("ah_rr_burst_scheduler: TIMEOUT must be 1..255");
    end

    logic [1:0]    r_state;
    logic [N-1:0]  r_grant;
    logic [PW-1:0] r_grant_id;
    logic [PW-1:0] r_ptr;
    logic [4:0]    r_len;
    logic [4:0]    r_beat_cnt;

    logic          w_win_found;
    logic [PW-1:0] w_win_id;
    logic [N-1:0]  w_win_onehot;
    logic [4:0]    w_len_sel;
    logic [4:0]    w_cnt_inc;
    logic [PW-1:0] w_ptr_next;
    logic          w_in_burst;
    logic          w_res_valid;
    logic          w_accept;
    logic          w_final_beat;
    logic          w_timeout;
    logic          w_burst_end;

    // Cyclic search starting at the pointer: the first requester found at or
    // after r_ptr (wrapping) wins.
    always_comb begin : arb
        int v_idx;
        w_win_found = 1'b0;
        w_win_id    = '0;
        for (int k = 0; k < N; k++) begin
            v_idx = int'(r_ptr) + k;
            if (v_idx >= N) begin
                v_idx = v_idx - N;
            end
            if (!w_win_found && req[v_idx]) begin
                w_win_found = 1'b1;
                w_win_id    = PW'(v_idx);
            end
        end
    end

    assign w_win_onehot = {{(N-1){1'b0}}, 1'b1} << w_win_id;
    assign w_len_sel    = (burst_len == 4'd0) ? 5'd16 : {1'b0, burst_len};
    assign w_cnt_inc    = r_beat_cnt + 5'd1;
    assign w_ptr_next   = (r_grant_id == PW'(N - 1)) ? '0 : r_grant_id + PW'(1);

    assign w_in_burst   = (r_state == S_BURST);
    assign w_res_valid  = w_in_burst & beat_valid[r_grant_id];
    assign w_accept     = w_res_valid & res_ready;
    assign w_final_beat = (w_cnt_inc == r_len);

`ifdef AH_RRS_TIMEOUT_EN
    logic [7:0] r_stall;
    logic [7:0] w_stall_inc;

    assign w_stall_inc = r_stall + 8'd1;
    // Abort fires in the stall cycle that would bring the counter to TIMEOUT,
    // so the pulse lands on exactly the TIMEOUT-th consecutive stall cycle.
    assign w_timeout   = w_in_burst & ~w_accept & (w_stall_inc == 8'(TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall <= 8'd0;
        end else if (r_state != S_BURST) begin
            r_stall <= 8'd0;
        end else if (w_accept) begin
            r_stall <= 8'd0;
        end else if (!w_timeout) begin
            r_stall <= w_stall_inc;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // A beat accepted in the same cycle as an early release still counts;
    // the count simply does not matter once we leave the burst.
    assign w_burst_end = (w_accept & w_final_beat) | ~req[r_grant_id] | w_timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_grant    <= '0;
            r_grant_id <= '0;
            r_ptr      <= '0;
            r_len      <= 5'd0;
            r_beat_cnt <= 5'd0;
        end else begin
            case (r_state)
                S_IDLE, S_GAP: begin
                    if (w_win_found) begin
                        r_state    <= S_BURST;
                        r_grant    <= w_win_onehot;
                        r_grant_id <= w_win_id;
                        r_len      <= w_len_sel;
                        r_beat_cnt <= 5'd0;
                    end else begin
                        r_state    <= S_IDLE;
                        r_grant    <= '0;
                        r_grant_id <= '0;
                    end
                end
                S_BURST: begin
                    if (w_accept) begin
                        r_beat_cnt <= w_cnt_inc;
                    end
                    if (w_burst_end) begin
                        r_state    <= S_GAP;
                        r_grant    <= '0;
                        r_grant_id <= '0;
                        r_ptr      <= w_ptr_next;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_grant    <= '0;
                    r_grant_id <= '0;
                end
            endcase
        end
    end

    assign grant     = r_grant;
    assign grant_id  = r_grant_id;
    assign res_valid = w_res_valid;
    assign res_last  = w_res_valid & w_final_beat & ~w_timeout;
    assign busy      = (r_state != S_IDLE);
    assign timeout   = w_timeout;

endmodule

// File: tb/tb_ah_rr_burst_scheduler.sv
// tb/tb_ah_rr_burst_scheduler.sv - self-checking bench for ah_rr_burst_scheduler

module tb_ah_rr_burst_scheduler;

    localparam int N  = 12;
    localparam int PW = 4;
    localparam int TO = 64;

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  req;
    logic [N-1:0]  beat_valid;
    logic [3:0]    burst_len;
    logic          res_ready;
    logic [N-1:0]  grant;
    logic [PW-1:0] grant_id;
    logic          res_valid;
    logic          res_last;
    logic          busy;
    logic          timeout;

    ah_rr_burst_scheduler #(.N(N), .PW(PW), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .beat_valid (beat_valid),
        .burst_len  (burst_len),
        .res_ready  (res_ready),
        .grant      (grant),
        .grant_id   (grant_id),
        .res_valid  (res_valid),
        .res_last   (res_last),
        .busy       (busy),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: owner/ptr/beat bookkeeping in plain integers.
    // m_mode: 0 = no owner and not turning around, 1 = owner holds the port, 2 = turnaround.
    int m_mode, m_owner, m_ptr, m_len, m_cnt, m_stall;

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_owner = 0; m_ptr = 0; m_len = 0; m_cnt = 0; m_stall = 0;
    endtask

    // Observation helpers for the directed sequences.
    int          glog[$];
    int          lastq[$];
    int          acc;
    logic [N-1:0] prev_grant;

    task automatic step(input logic [N-1:0] rq, input logic [N-1:0] bv,
                        input logic [3:0] bl, input logic rdy);
        logic [N-1:0] one;
        logic [N-1:0] e_grant;
        int  e_gid, w;
        logic e_rv, e_rl, e_to, e_acc, done;
        @(negedge clk);
        req = rq; beat_valid = bv; burst_len = bl; res_ready = rdy;
        #1;
        one     = 1;
        e_grant = (m_mode == 1) ? (one << m_owner) : '0;
        e_gid   = (m_mode == 1) ? m_owner : 0;
        e_rv    = (m_mode == 1) && bv[m_owner];
        e_acc   = e_rv && rdy;
        e_to    = 1'b0;
`ifdef AH_RRS_TIMEOUT_EN
        e_to    = (m_mode == 1) && !e_acc && (m_stall + 1 == TO);
`endif
        e_rl    = e_rv && (m_cnt + 1 == m_len) && !e_to;
        chk("grant",     32'(grant),     32'(e_grant));
        chk("grant_id",  32'(grant_id),  32'(e_gid));
        chk("res_valid", 32'(res_valid), 32'(e_rv));
        chk("res_last",  32'(res_last),  32'(e_rl));
        chk("busy",      32'(busy),      32'(m_mode != 0));
        chk("timeout",   32'(timeout),   32'(e_to));
        // advance the model across the coming rising edge
        if (m_mode == 1) begin
            done = (e_acc && (m_cnt + 1 == m_len)) || !rq[m_owner] || e_to;
            if (e_acc) begin m_cnt++; m_stall = 0; end
            else m_stall++;
            if (done) begin
                m_ptr  = (m_owner + 1) % N;
                m_mode = 2;
            end
        end else begin
            w = rr_pick(rq, m_ptr);
            if (w >= 0) begin
                m_mode = 1; m_owner = w; m_cnt = 0; m_stall = 0;
                m_len  = (bl == 0) ? 16 : int'(bl);
            end else begin
                m_mode = 0;
            end
        end
        // observations for directed checks
        if (grant != '0 && prev_grant == '0) glog.push_back(int'(grant_id));
        prev_grant = grant;
        if (res_last) lastq.push_back(acc);
        if (res_valid && res_ready) acc++;
    endtask

    task automatic obs_clear();
        glog.delete(); lastq.delete(); acc = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; req = '0; beat_valid = '0; burst_len = 4'd0; res_ready = 1'b0;
        #1;
        model_reset();
        chk("rst_grant",     32'(grant),     32'd0);
        chk("rst_grant_id",  32'(grant_id),  32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_last",  32'(res_last),  32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_timeout",   32'(timeout),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        prev_grant = '0;
        obs_clear();
    endtask

    typedef struct {
        logic [N-1:0] rq;
        logic [N-1:0] bv;
        logic [3:0]   bl;
        logic         rdy;
        logic [N-1:0] e_grant;
        logic         e_rv;
        logic         e_rl;
        logic         e_busy;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int gap_step, drop_step, stalls, to_at, n_to, n_bad;
        logic seen, seen_gap;
        logic [N-1:0] rq, bv;

        // single requester, len 4: grant after one cycle, 4 beats, gap, re-grant
        tbl[0] = '{12'h001, 12'h001, 4'd4, 1'b1, 12'h000, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{12'h001, 12'h001, 4'd4, 1'b1, 12'h001, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{12'h001, 12'h001, 4'd4, 1'b1, 12'h001, 1'b1, 1'b0, 1'b1};
        tbl[3] = '{12'h001, 12'h001, 4'd4, 1'b1, 12'h001, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{12'h001, 12'h001, 4'd4, 1'b1, 12'h001, 1'b1, 1'b1, 1'b1};
        tbl[5] = '{12'h001, 12'h001, 4'd4, 1'b1, 12'h000, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{12'h001, 12'h001, 4'd4, 1'b1, 12'h001, 1'b1, 1'b0, 1'b1};

        rst_n = 1'b0; req = '0; beat_valid = '0; burst_len = 4'd0; res_ready = 1'b0;
        prev_grant = '0;
        model_reset();
        obs_clear();

        do_reset();
        for (int i = 0; i < 7; i++) begin
            step(tbl[i].rq, tbl[i].bv, tbl[i].bl, tbl[i].rdy);
            chk("tbl_grant",     32'(grant),     32'(tbl[i].e_grant));
            chk("tbl_res_valid", 32'(res_valid), 32'(tbl[i].e_rv));
            chk("tbl_res_last",  32'(res_last),  32'(tbl[i].e_rl));
            chk("tbl_busy",      32'(busy),      32'(tbl[i].e_busy));
        end

        // all requesting, len 1: order 0..11 then wrap to 0
        do_reset();
        for (int i = 0; i < 28; i++) step(12'hFFF, 12'hFFF, 4'd1, 1'b1);
        chk("rr_count_ge13", 32'(glog.size() >= 13), 32'd1);
        for (int i = 0; i < 13; i++)
            chk("rr_order", (glog.size() > i) ? 32'(glog[i]) : 32'hFFFF_FFFF, 32'(i % N));

        // pointer at 5 with requesters 3 and 7: 7, then 3, then 7
        do_reset();
        step(12'h010, 12'hFFF, 4'd1, 1'b1);
        step(12'h010, 12'hFFF, 4'd1, 1'b1);
        for (int i = 0; i < 8; i++) step(12'h088, 12'hFFF, 4'd1, 1'b1);
        chk("ptr5_count", 32'(glog.size() >= 4), 32'd1);
        chk("ptr5_first",  (glog.size() > 1) ? 32'(glog[1]) : 32'hFFFF_FFFF, 32'd7);
        chk("ptr5_second", (glog.size() > 2) ? 32'(glog[2]) : 32'hFFFF_FFFF, 32'd3);
        chk("ptr5_third",  (glog.size() > 3) ? 32'(glog[3]) : 32'hFFFF_FFFF, 32'd7);

        // owner 2, len 16, ready toggling
        do_reset();
        seen = 1'b0; seen_gap = 1'b0;
        for (int i = 0; i < 80 && !seen_gap; i++) begin
            step(12'h004, 12'hFFF, 4'd0, 1'(i % 2 == 0));
            if (grant != '0) seen = 1'b1;
            else if (seen) seen_gap = 1'b1;
        end
        chk("len16_gap_reached", 32'(seen_gap), 32'd1);
        chk("len16_beats", 32'(acc), 32'd16);
        chk("len16_last_seen", 32'(lastq.size() > 0), 32'd1);
        n_bad = 0;
        foreach (lastq[j]) if (lastq[j] != 15) n_bad++;
        chk("len16_last_only_16th", 32'(n_bad), 32'd0);

        // re-granted; owner drops req after the 5th accepted beat
        obs_clear();
        seen = 1'b0; drop_step = -1; gap_step = -1;
        for (int i = 0; i < 60 && gap_step < 0; i++) begin
            rq = (acc >= 5) ? 12'h000 : 12'h004;
            if (acc >= 5 && drop_step < 0) drop_step = i;
            step(rq, 12'hFFF, 4'd0, 1'(i % 2 == 0));
            if (grant != '0) seen = 1'b1;
            else if (seen) begin
                gap_step = i;
                chk("drop_gap_busy", 32'(busy), 32'd1);
            end
        end
        chk("drop_gap_next_cycle", 32'(gap_step - drop_step), 32'd1);
        chk("drop_no_last", 32'(lastq.size()), 32'd0);

        // asynchronous reset during beat 3 of 8
        do_reset();
        for (int i = 0; i < 4; i++) step(12'h001, 12'h001, 4'd8, 1'b1);
        chk("mid_pre_grant", 32'(grant), 32'h001);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_grant",     32'(grant),     32'd0);
        chk("mid_rst_res_valid", 32'(res_valid), 32'd0);
        chk("mid_rst_busy",      32'(busy),      32'd0);
        model_reset();
        req = '0; beat_valid = '0; burst_len = 4'd0; res_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        prev_grant = '0;
        step(12'h800, 12'hFFF, 4'd8, 1'b1);
        step(12'h800, 12'hFFF, 4'd8, 1'b1);
        chk("mid_after_grant_id", 32'(grant_id), 32'd11);
        chk("mid_after_grant",    32'(grant),    32'h800);

        // stalled owner 0 with requester 1 waiting
        do_reset();
`ifdef AH_RRS_TIMEOUT_EN
        stalls = 0; to_at = -1; n_to = 0;
        for (int i = 0; i < 120 && to_at < 0; i++) begin
            bv = (acc < 2) ? 12'h001 : 12'h000;
            step(12'h003, bv, 4'd8, 1'b1);
            if (grant == 12'h001 && !res_valid) stalls++;
            if (timeout) begin to_at = stalls; n_to++; end
        end
        chk("to_at_64th_stall", 32'(to_at), 32'(TO));
        step(12'h003, 12'h000, 4'd8, 1'b1);
        chk("to_gap_grant", 32'(grant), 32'd0);
        chk("to_gap_busy",  32'(busy),  32'd1);
        chk("to_gap_pulse", 32'(timeout), 32'd0);
        step(12'h003, 12'h000, 4'd8, 1'b1);
        chk("to_next_owner", 32'(grant), 32'h002);
`else
        n_bad = 0;
        step(12'h003, 12'h001, 4'd8, 1'b1);
        for (int i = 0; i < 210; i++) begin
            bv = (acc < 2) ? 12'h001 : 12'h000;
            step(12'h003, bv, 4'd8, 1'b1);
            if (grant != 12'h001 || timeout) n_bad++;
        end
        chk("stall_hold_grant", 32'(n_bad), 32'd0);
        chk("stall_beats", 32'(acc), 32'd2);
`endif

        // randomized traffic against the model
        do_reset();
        rq = '0;
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 15) == 0) rq[b] = ~rq[b];
            for (int b = 0; b < N; b++)
                bv[b] = ($urandom_range(0, 3) != 0);
            step(rq, bv, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ah_rr_burst_scheduler.md
# ah_rr_burst_scheduler

Burst-level round-robin scheduler that shares one downstream resource port among N requesters. It grants a single requester for a whole burst of up to 16 beats, counts accepted beats, and releases the grant on burst completion or early release. After each release it inserts a one-cycle turnaround and rotates priority to the requester after the previous owner. It sits in front of the shared AH datapath, which sees one muxed valid/last stream and returns a ready.

## Interface
Parameters:
- N, 12, number of requesters (2..16)
- PW, 4, width of owner index; must satisfy 2^PW >= N
- TIMEOUT, 64, stall-cycle limit used only when AH_RRS_TIMEOUT_EN is defined (1..255)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req  in  N  per-requester burst request; level, held for the duration of the burst
- beat_valid  in  N  per-requester beat valid
- burst_len  in  4  beats per burst; 0 encodes 16; sampled when a grant is issued
- res_ready  in  1  shared resource accepts the current beat
- grant  out  N  registered one-hot owner, all zero when idle or in gap
- grant_id  out  PW  index of the current owner; 0 when no grant
- res_valid  out  1  beat_valid[grant_id] while in BURST, else 0
- res_last  out  1  res_valid high and the current beat is the final counted beat
- busy  out  1  state != IDLE
- timeout  out  1  one-cycle abort pulse

## Operation
- State machine with states IDLE, BURST, and GAP:
  - IDLE: if |req, register the round-robin winner into grant/grant_id, latch len = (burst_len==0 ? 16 : burst_len), clear beat_cnt, and go to BURST. Otherwise stay in IDLE.
  - BURST: an accepted beat is res_valid & res_ready, and it increments beat_cnt (5 bits). The burst ends when either (a) the accepted beat has beat_cnt+1 == len, or (b) req[grant_id] is low. In case (b), a beat accepted in the same cycle is still counted. When the burst ends, the next state is GAP and the pointer updates to grant_id+1, wrapping N-1 -> 0.
  - GAP: grant is 0. Arbitration uses the updated pointer. If |req, issue the new grant and go to BURST; otherwise go to IDLE.
- Round-robin rule: the winner is the lowest index i whose req[i] is high, searching cyclically from the pointer. After reset the pointer is 0.
- The owner may drop beat_valid mid-burst; this only stalls the count.
- Non-owner req and beat_valid have no effect during BURST.
- A req that drops before it is granted is not remembered.

## Timing
- Reset values: grant=0, grant_id=0, res_valid=0, res_last=0, busy=0, timeout=0, pointer=0, beat_cnt=0, state IDLE.
- Grant latency: req sampled high in IDLE at edge t gives grant at t+1.
- res_valid and res_last are combinational from the registered state and beat_valid; they have no added latency.
- Back-to-back bursts: the last beat is accepted at cycle t, grant=0 at t+1 (GAP), and the next grant appears at t+2. Minimum turnaround is exactly one idle cycle.
- A single requester holding req continuously is re-granted every (len + 1 gap) cycles when ready is always high.
- Reset asserted mid-burst: all outputs clear asynchronously. No partial-burst state survives.
- A burst_len change during BURST has no effect until the next grant.

## Configuration
- AH_RRS_TIMEOUT_EN defined:
  - An 8-bit stall counter clears on grant and on every accepted beat, and increments on every other BURST cycle.
  - When the counter reaches TIMEOUT, the burst aborts: timeout pulses for one cycle in that BURST cycle, res_last=0, and the next state is GAP with a normal pointer update.
- AH_RRS_TIMEOUT_EN undefined: no counter is built, timeout is tied to 0, and a stalled owner holds the grant indefinitely.

## Test plan
- Reset, then req=12'h001 with burst_len=4, beat_valid[0]=1, and res_ready=1. Expected: grant=12'h001 one cycle after req, four res_valid beats with res_last on the 4th, then one gap cycle, then re-grant.
- req=12'hFFF held, burst_len=1, ready=1. Expected: grants in order 0,1,2,...,11,0, each followed by a gap cycle, and grant_id wraps 11 -> 0.
- Requesters 3 and 7 request, pointer at 5. Expected: 7 wins. After its burst, 3 wins, then 7 again.
- Owner 2 with burst_len=0 and res_ready toggling 1,0,1,0. Expected: exactly 16 accepted beats and res_last only on the 16th. Owner 2 then drops req after the 5th accepted beat. Expected: GAP the next cycle with no res_last.
- rst_n pulled low mid-burst at beat 3 of 8. Expected: grant, res_valid, and busy are 0 immediately. After release, req=12'h800 is granted at pointer 0 search, so 11 wins.
- With AH_RRS_TIMEOUT_EN and TIMEOUT=64, owner 0 holds beat_valid=0 after 2 beats. Expected: a timeout pulse on the 64th stall cycle, then GAP, and grant passes to requester 1 if it is requesting. Without the macro, the same stimulus keeps grant=12'h001 for at least 200 cycles.
